// File: rtl/order_4_1.sv
// order_4_1: parallel-to-serial output stage for the 4-input sort network.
//
// Accepts one sorted group of four words in parallel and emits it one word per beat over a
// valid/ready stream. Word 0 (largest) goes first and word 3 (smallest) goes last. Each
// accepted group is checked for non-increasing order. A violation sets the sticky order_err
// flag. The data is still sent unchanged.
//
// Parameters:
//   DSIZE        data word width in bits
//   CHECK_ORDER  1 = order check active, 0 = order_err tied low
//
// Build option:
//   ORDER_4_1_PIPE_EN  when defined, a new group may be accepted in the same cycle as the last
//                      beat of the current group. This removes the idle bubble between groups.
//
// Ports:
//   clock      single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   group present on indata0..3
//   in_ready   block accepts a group this cycle
//   indata0..3 sorted words, indata0 largest
//   out_valid  outdata valid
//   out_ready  downstream accepts the beat
//   outdata    serial data word
//   out_idx    position of outdata within its group
//   out_last   high with out_idx == 3
//   order_err  sticky: an accepted group was not non-increasing
//   err_clr    synchronous clear of order_err (a simultaneous new error wins)
module order_4_1 #(
    parameter int unsigned DSIZE       = 8,
    parameter bit          CHECK_ORDER = 1'b1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] indata0,
    input  logic [DSIZE-1:0] indata1,
    input  logic [DSIZE-1:0] indata2,
    input  logic [DSIZE-1:0] indata3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] outdata,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             order_err,
    input  logic             err_clr
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [3:0][DSIZE-1:0]   g_q, g_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    order_err_q, order_err_d;

    logic accept;
    logic beat;
    logic last_beat;
    logic grp_err;

    assign accept    = in_valid & in_ready;
    assign beat      = out_valid & out_ready;
    assign last_beat = beat & (cnt_q == 2'd3);

    // Unsigned neighbour compares. Equal neighbours are legal.
    assign grp_err = CHECK_ORDER &
                     ((indata0 < indata1) | (indata1 < indata2) | (indata2 < indata3));

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An overlapped accept on the last beat keeps the FSM in StSend.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (last_beat && !accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode. The stream outputs depend only on registered state, so they stay stable
    // under backpressure.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        outdata   = '0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
            end
            StSend: begin
                out_valid = 1'b1;
                outdata   = g_q[cnt_q];
                out_idx   = cnt_q;
                out_last  = (cnt_q == 2'd3);
`ifdef ORDER_4_1_PIPE_EN
                in_ready  = (cnt_q == 2'd3) & out_ready;
`else
                in_ready  = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Group registers, beat counter and sticky error flag.
    always_comb begin
        g_d         = g_q;
        cnt_d       = cnt_q;
        order_err_d = order_err_q;

        if (beat && (cnt_q != 2'd3)) begin
            cnt_d = cnt_q + 2'd1;
        end
        // Accept is checked after the beat so an overlapped load restarts the count.
        if (accept) begin
            g_d[0] = indata0;
            g_d[1] = indata1;
            g_d[2] = indata2;
            g_d[3] = indata3;
            cnt_d  = 2'd0;
        end

        if (accept && grp_err) begin
            order_err_d = 1'b1;
        end else if (err_clr) begin
            order_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            g_q         <= '0;
            cnt_q       <= 2'd0;
            order_err_q <= 1'b0;
        end else begin
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;

endmodule

// File: tb/tb_order_4_1.sv
// Self-checking bench for order_4_1. A reference model updates at each rising edge. On every
// accepted group it pushes the four expected beats into a scoreboard queue. It also tracks the
// count of beats still owed and the expected sticky error flag. A monitor on the falling edge
// compares the DUT outputs against the model and pops the queue on each beat.
module tb_order_4_1;

    localparam int unsigned DSIZE      = 8;
    localparam bit          CheckOrder = 1'b1;
`ifdef ORDER_4_1_PIPE_EN
    localparam bit          Pipe       = 1'b1;
`else
    localparam bit          Pipe       = 1'b0;
`endif

    typedef struct {
        logic [DSIZE-1:0] data;
        logic [1:0]       idx;
    } beat_t;

    logic             clock;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] indata0, indata1, indata2, indata3;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] outdata;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             order_err;
    logic             err_clr;

    int    vectors    = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    int    rem        = 0;   // beats still owed by the DUT
    bit    exp_err    = 1'b0;
    bit    rand_mode  = 1'b0;

    order_4_1 #(
        .DSIZE      (DSIZE),
        .CHECK_ORDER(CheckOrder)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .indata0  (indata0),
        .indata1  (indata1),
        .indata2  (indata2),
        .indata3  (indata3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outdata  (outdata),
        .out_idx  (out_idx),
        .out_last (out_last),
        .order_err(order_err),
        .err_clr  (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated at each rising edge on the inputs held across that edge.
    initial begin
        bit rdy;
        bit acc;
        bit bad;
        forever begin
            @(posedge clock);
            if (!rst_n) begin
                rem = 0;
                exp_q.delete();
                exp_err = 1'b0;
            end else begin
                rdy = (rem == 0) || (Pipe && rem == 1 && out_ready);
                acc = in_valid && rdy;
                bad = CheckOrder && ((indata0 < indata1) || (indata1 < indata2) ||
                                     (indata2 < indata3));
                if (rem != 0 && out_ready) rem--;
                if (acc) begin
                    rem = 4;
                    exp_q.push_back('{data: indata0, idx: 2'd0});
                    exp_q.push_back('{data: indata1, idx: 2'd1});
                    exp_q.push_back('{data: indata2, idx: 2'd2});
                    exp_q.push_back('{data: indata3, idx: 2'd3});
                end
                if (acc && bad) exp_err = 1'b1;
                else if (err_clr) exp_err = 1'b0;
            end
        end
    end

    // Monitor: samples mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_outdata", outdata, 0);
                check("rst_out_idx", out_idx, 0);
                check("rst_out_last", out_last, 0);
                check("rst_order_err", order_err, 0);
            end else begin
                check("out_valid", out_valid, (rem != 0));
                check("in_ready", in_ready, (rem == 0) || (Pipe && rem == 1 && out_ready));
                check("order_err", order_err, exp_err);
                if (out_valid && exp_q.size() > 0) begin
                    check("outdata", outdata, exp_q[0].data);
                    check("out_idx", out_idx, exp_q[0].idx);
                    check("out_last", out_last, (exp_q[0].idx == 2'd3));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Present a group and hold it until accepted. in_valid is left high for the caller.
    task automatic send_group(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        indata0  = a;
        indata1  = b;
        indata2  = c;
        indata3  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            done = in_ready;
            tick();
        end
        check("accept_timeout", done, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            done = !out_valid;
            tick();
        end
        check("drain_timeout", done, 1);
    endtask

    initial begin
        logic [7:0] v[4];
        logic [7:0] t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        indata0   = '0;
        indata1   = '0;
        indata2   = '0;
        indata3   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic serialize.
        send_group(8'hF0, 8'h80, 8'h40, 8'h01);
        in_valid = 1'b0;
        drain();

        // Backpressure: stall for 3 cycles while word 1 is offered.
        send_group(8'hF0, 8'h80, 8'h40, 8'h01);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        drain();

        // Order error, then a legal all-equal group that leaves the flag set.
        send_group(8'h10, 8'h20, 8'h05, 8'h05);
        in_valid = 1'b0;
        drain();
        send_group(8'h05, 8'h05, 8'h05, 8'h05);
        in_valid = 1'b0;
        drain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // Clear and set on the same edge: set wins. Then clear alone.
        err_clr = 1'b1;
        send_group(8'h00, 8'hFF, 8'h00, 8'h00);
        err_clr  = 1'b0;
        in_valid = 1'b0;
        drain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // Reset while word 2 of an erroneous group is offered.
        send_group(8'h01, 8'h02, 8'h03, 8'h04);
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Back-to-back groups with in_valid held high.
        send_group(8'd4, 8'd3, 8'd2, 8'd1);
        send_group(8'd8, 8'd7, 8'd6, 8'd5);
        in_valid = 1'b0;
        drain();

        // Randomized traffic: random data, idle gaps, backpressure and clears.
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 4; k++) v[k] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (v[j] < v[j+1]) begin
                            t      = v[j];
                            v[j]   = v[j+1];
                            v[j+1] = t;
                        end
                    end
                end
            end
            send_group(v[0], v[1], v[2], v[3]);
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        in_valid  = 1'b0;
        rand_mode = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        drain();
        repeat (2) tick();
        check("beats_outstanding", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
